cim_step_sequencer: RTL and testbench

CIM_STEP_SEQUENCER -- requirements
Module: cim_step_sequencer

---
 rtl/cim_step_sequencer_pkg.sv | 19 +
 rtl/cim_step_sequencer_counter.sv | 27 ++
 rtl/cim_step_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cim_step_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_step_sequencer_pkg.sv
// Shared definitions for the CIM inference step sequencer: FSM state encoding
// and default parameter values.
package cim_step_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        PAUSED,
        DONE,
        ERROR
    } SeqState_t;

    localparam int DEF_NUM_STEPS = 8;
    localparam int DEF_ITER_W    = 9;
    localparam int DEF_TIMEOUT_W = 16;

endpackage

// File: rtl/cim_step_sequencer_counter.sv
// Up-counter with synchronous clear (priority over increment) that saturates
// at all-ones instead of wrapping.
module cim_step_sequencer_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cim_step_sequencer.sv
// Sequences NUM_STEPS inference steps, each a programmable number of compute
// iterations, with optional per-step pause, watchdog timeout and abort.
module cim_step_sequencer
    import cim_step_sequencer_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int ITER_W    = DEF_ITER_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          new_sleep_epoch,
    input  logic                          abort,
    input  logic                          step_mode,
    input  logic                          resume,
    input  logic [NUM_STEPS*ITER_W-1:0]   step_len,
    input  logic [TIMEOUT_W-1:0]          timeout_limit,
    output logic                          compute_start,
    input  logic                          compute_done,
    output logic [$clog2(NUM_STEPS)-1:0]  cur_step,
    output logic [ITER_W-1:0]             iter_idx,
    output logic                          busy,
    output logic                          paused,
    output logic                          inference_done,
    output logic                          error
);

    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    SeqState_t             r_state;
    SeqState_t             w_next;
    SeqState_t             w_end_next;
    logic [STEP_W-1:0]     r_cur_step;
    logic                  r_compute_start;
    logic                  r_busy;
    logic                  r_paused;
    logic                  r_done;
    logic                  r_error;

    logic [ITER_W-1:0]     w_iter;
    logic [TIMEOUT_W-1:0]  w_wd;
    logic [ITER_W-1:0]     w_len;
    logic                  w_last_step;
    logic                  w_last_iter;
    logic                  w_timeout;
    logic                  w_end_adv;
    logic                  w_iter_clr;
    logic                  w_iter_inc;
    logic                  w_wd_clr;
    logic                  w_wd_inc;
    logic                  w_step_clr;
    logic                  w_step_inc;
    logic                  w_err_clr;

    assign w_len       = step_len[int'(r_cur_step)*ITER_W +: ITER_W];
    assign w_last_step = (r_cur_step == LAST_STEP);
    assign w_last_iter = (w_iter == (w_len - ITER_W'(1)));
    assign w_timeout   = (timeout_limit != '0) && (w_wd == (timeout_limit - TIMEOUT_W'(1)));

    // Step-end handling is shared by zero-length skip in SETUP and last iteration in WAIT
    assign w_end_next = w_last_step ? DONE : (step_mode ? PAUSED : SETUP);
    assign w_end_adv  = !w_last_step && !step_mode;

    always_comb begin
        w_next     = r_state;
        w_iter_clr = 1'b0;
        w_iter_inc = 1'b0;
        w_wd_clr   = 1'b0;
        w_wd_inc   = 1'b0;
        w_step_clr = 1'b0;
        w_step_inc = 1'b0;
        w_err_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (new_sleep_epoch) begin
                    w_next     = SETUP;
                    w_step_clr = 1'b1;
                    w_iter_clr = 1'b1;
                    w_err_clr  = 1'b1;
                end
            end
            SETUP: begin
                if (w_len != '0) begin
                    w_next = ISSUE;
                end else begin
                    w_next     = w_end_next;
                    w_step_inc = w_end_adv;
                    w_iter_clr = w_end_adv;
                end
            end
            ISSUE: begin
                w_next   = WAIT;
                w_wd_clr = 1'b1;
            end
            WAIT: begin
                w_wd_inc = 1'b1;
                if (compute_done) begin
                    if (w_last_iter) begin
                        w_next     = w_end_next;
                        w_step_inc = w_end_adv;
                        w_iter_clr = w_end_adv;
                    end else begin
                        w_next     = ISSUE;
                        w_iter_inc = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = ERROR;
                end
            end
            PAUSED: begin
                if (resume) begin
                    w_next     = SETUP;
                    w_step_inc = 1'b1;
                    w_iter_clr = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            ERROR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Abort overrides every other event and discards progress
        if (abort && (r_state != IDLE)) begin
            w_next     = IDLE;
            w_step_inc = 1'b0;
            w_step_clr = 1'b1;
            w_iter_inc = 1'b0;
            w_iter_clr = 1'b1;
            w_wd_inc   = 1'b0;
            w_wd_clr   = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cur_step      <= '0;
            r_compute_start <= 1'b0;
            r_busy          <= 1'b0;
            r_paused        <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_compute_start <= (w_next == ISSUE);
            r_busy          <= (w_next != IDLE);
            r_paused        <= (w_next == PAUSED);
            r_done          <= (w_next == DONE);
            if (w_step_clr) begin
                r_cur_step <= '0;
            end else if (w_step_inc) begin
                r_cur_step <= r_cur_step + STEP_W'(1);
            end
            if (w_err_clr) begin
                r_error <= 1'b0;
            end else if (w_next == ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

    cim_step_sequencer_counter #(.W(ITER_W)) u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_iter_clr),
        .i_inc (w_iter_inc),
        .o_cnt (w_iter)
    );

    cim_step_sequencer_counter #(.W(TIMEOUT_W)) u_wd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_wd_clr),
        .i_inc (w_wd_inc),
        .o_cnt (w_wd)
    );

    assign compute_start  = r_compute_start;
    assign cur_step       = r_cur_step;
    assign iter_idx       = w_iter;
    assign busy           = r_busy;
    assign paused         = r_paused;
    assign inference_done = r_done;
    assign error          = r_error;

endmodule

// File: tb/tb_cim_step_sequencer.sv
// Directed bench for cim_step_sequencer with NUM_STEPS=3: table-driven full
// inferences plus hand-written pause, timeout, abort and reset sequences.
module tb_cim_step_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_sleep_epoch = 1'b0;
    logic        abort = 1'b0;
    logic        step_mode = 1'b0;
    logic        resume = 1'b0;
    logic [11:0] step_len = '0;
    logic [7:0]  timeout_limit = '0;
    logic        compute_start;
    logic        compute_done = 1'b0;
    logic [1:0]  cur_step;
    logic [3:0]  iter_idx;
    logic        busy;
    logic        paused;
    logic        inference_done;
    logic        error;

    cim_step_sequencer #(.NUM_STEPS(3), .ITER_W(4), .TIMEOUT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .new_sleep_epoch (new_sleep_epoch),
        .abort           (abort),
        .step_mode       (step_mode),
        .resume          (resume),
        .step_len        (step_len),
        .timeout_limit   (timeout_limit),
        .compute_start   (compute_start),
        .compute_done    (compute_done),
        .cur_step        (cur_step),
        .iter_idx        (iter_idx),
        .busy            (busy),
        .paused          (paused),
        .inference_done  (inference_done),
        .error           (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] len;
        int          starts;
        int          lat;
        int          s0;
        int          s1;
        int          s2;
    } vec_t;

    vec_t vt[6];
    int   n_chk = 0;
    int   n_fail = 0;

    int   r_starts, r_lat, r_dones, r_pauses, r_pcycles, r_viol;
    int   sps[4];
    int   pstep[4];
    logic r_fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full inference with an auto-responder answering each compute_start one cycle later
    task automatic run_inf(input logic [11:0] len, input logic mode);
        int   hold;
        logic prev_start;
        logic pend;
        step_len      = len;
        step_mode     = mode;
        timeout_limit = '0;
        r_starts = 0; r_lat = 0; r_dones = 0; r_pauses = 0; r_pcycles = 0; r_viol = 0;
        for (int i = 0; i < 4; i++) begin
            sps[i]   = 0;
            pstep[i] = 0;
        end
        r_fin = 1'b0;
        hold = 0; prev_start = 1'b0; pend = 1'b0;
        new_sleep_epoch = 1'b1;
        step_cycle();
        new_sleep_epoch = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            compute_done = prev_start;
            resume = 1'b0;
            if (compute_start) begin
                r_starts++;
                sps[cur_step]++;
                if (pend) r_viol++;
            end
            prev_start = compute_start;
            if (inference_done) begin
                r_dones++;
                r_lat = k;
            end
            if (paused) begin
                if (hold == 0) begin
                    if (r_pauses < 4) pstep[r_pauses] = int'(cur_step);
                    r_pauses++;
                end
                r_pcycles++;
                hold++;
                pend = 1'b1;
                if (hold == 3) begin
                    resume = 1'b1;
                    hold = 0;
                    pend = 1'b0;
                end
            end
            if (!busy) begin
                r_fin = 1'b1;
                break;
            end
            step_cycle();
        end
        compute_done = 1'b0;
        resume = 1'b0;
        step_mode = 1'b0;
    endtask

    initial begin
        int pulses;

        vt[0] = '{12'h312, 6, 16, 2, 1, 3};
        vt[1] = '{12'h203, 5, 14, 3, 0, 2};
        vt[2] = '{12'h111, 3, 10, 1, 1, 1};
        vt[3] = '{12'h100, 1,  6, 0, 0, 1};
        vt[4] = '{12'h000, 0,  4, 0, 0, 0};
        vt[5] = '{12'h00F, 15, 34, 15, 0, 0};

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_start", compute_start, 0);
        chk("rst_paused", paused, 0);
        chk("rst_done", inference_done, 0);
        chk("rst_error", error, 0);
        chk("rst_cur_step", cur_step, 0);
        chk("rst_iter_idx", iter_idx, 0);
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
        step_cycle();
        step_cycle();
        chk("post_rst_busy", busy, 0);

        for (int v = 0; v < 6; v++) begin
            run_inf(vt[v].len, 1'b0);
            chk($sformatf("v%0d_finished", v), r_fin, 1);
            chk($sformatf("v%0d_starts", v), r_starts, vt[v].starts);
            chk($sformatf("v%0d_latency", v), r_lat, vt[v].lat);
            chk($sformatf("v%0d_step0", v), sps[0], vt[v].s0);
            chk($sformatf("v%0d_step1", v), sps[1], vt[v].s1);
            chk($sformatf("v%0d_step2", v), sps[2], vt[v].s2);
            chk($sformatf("v%0d_done_cnt", v), r_dones, 1);
            chk($sformatf("v%0d_pauses", v), r_pauses, 0);
            chk($sformatf("v%0d_error", v), error, 0);
            step_cycle();
        end

        // Step mode: pause after steps 0 and 1, 3 cycles each
        run_inf(12'h312, 1'b1);
        chk("sm_finished", r_fin, 1);
        chk("sm_starts", r_starts, 6);
        chk("sm_pauses", r_pauses, 2);
        chk("sm_pause_step0", pstep[0], 0);
        chk("sm_pause_step1", pstep[1], 1);
        chk("sm_pause_cycles", r_pcycles, 6);
        chk("sm_start_in_pause", r_viol, 0);
        chk("sm_latency", r_lat, 22);
        chk("sm_done_cnt", r_dones, 1);
        step_cycle();

        // Timeout: 5 WAIT cycles (3..7) then ERROR in cycle 8, IDLE in cycle 9
        step_len = 12'h312;
        timeout_limit = 8'd5;
        new_sleep_epoch = 1'b1;
        step_cycle();
        new_sleep_epoch = 1'b0;
        step_cycle();
        chk("to_issue_start", compute_start, 1);
        step_cycle();
        step_cycle();
        new_sleep_epoch = 1'b1;
        step_cycle();
        new_sleep_epoch = 1'b0;
        step_cycle();
        step_cycle();
        chk("to_cycle7_error", error, 0);
        chk("to_cycle7_busy", busy, 1);
        step_cycle();
        chk("to_cycle8_error", error, 1);
        chk("to_cycle8_busy", busy, 1);
        step_cycle();
        chk("to_cycle9_busy", busy, 0);
        chk("to_cycle9_error_sticky", error, 1);
        step_cycle();
        chk("to_error_held", error, 1);

        // compute_done on the timeout cycle wins; new epoch clears error
        step_len = 12'h001;
        new_sleep_epoch = 1'b1;
        step_cycle();
        new_sleep_epoch = 1'b0;
        chk("tie_error_cleared", error, 0);
        for (int c = 2; c <= 7; c++) step_cycle();
        compute_done = 1'b1;
        step_cycle();
        compute_done = 1'b0;
        chk("tie_cycle8_error", error, 0);
        chk("tie_cycle8_busy", busy, 1);
        step_cycle();
        step_cycle();
        chk("tie_cycle10_done", inference_done, 1);
        step_cycle();
        chk("tie_cycle11_busy", busy, 0);
        chk("tie_cycle11_error", error, 0);
        timeout_limit = '0;

        // Abort in WAIT of iteration 1
        step_len = 12'h312;
        new_sleep_epoch = 1'b1;
        step_cycle();
        new_sleep_epoch = 1'b0;
        step_cycle();
        step_cycle();
        compute_done = 1'b1;
        step_cycle();
        compute_done = 1'b0;
        step_cycle();
        chk("ab_iter_before", iter_idx, 1);
        abort = 1'b1;
        compute_done = 1'b1;
        step_cycle();
        abort = 1'b0;
        compute_done = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_start", compute_start, 0);
        chk("ab_paused", paused, 0);
        chk("ab_done", inference_done, 0);
        chk("ab_error", error, 0);
        chk("ab_cur_step", cur_step, 0);
        chk("ab_iter_idx", iter_idx, 0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            compute_done = 1'b1;
            resume = 1'b1;
            step_cycle();
            pulses += int'(compute_start) + int'(inference_done) + int'(busy);
        end
        compute_done = 1'b0;
        resume = 1'b0;
        chk("ab_idle_quiet", pulses, 0);

        // Asynchronous reset mid-step
        new_sleep_epoch = 1'b1;
        step_cycle();
        new_sleep_epoch = 1'b0;
        step_cycle();
        step_cycle();
        compute_done = 1'b1;
        step_cycle();
        compute_done = 1'b0;
        step_cycle();
        chk("rs_iter_before", iter_idx, 1);
        chk("rs_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_start", compute_start, 0);
        chk("rs_iter_idx", iter_idx, 0);
        chk("rs_cur_step", cur_step, 0);
        chk("rs_paused", paused, 0);
        chk("rs_error", error, 0);
        step_cycle();
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step_cycle();
            pulses += int'(compute_start) + int'(inference_done) + int'(busy) + int'(error);
        end
        chk("rs_release_quiet", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
